// File: rtl/dpd_unpack_stream_pkg.sv
// Shared types and helpers for the densely-packed-decimal receive path.
package dpd_pkg;

  localparam int DECLET_W = 10;
  localparam int DIGIT_W  = 4;

  typedef struct packed {
    logic [DIGIT_W-1:0] d2;
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } bcd3_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // The 24 redundant encodings of the all-large pattern: a/b set where they are don't-care.
  function automatic logic dpd_is_noncanon(input logic [DECLET_W-1:0] dpd);
    return dpd[6] & dpd[5] & dpd[3] & dpd[2] & dpd[1] & (dpd[9] | dpd[8]);
  endfunction

endpackage

// File: rtl/dpd_unpack_stream_unpack.sv
// Combinational declet-to-three-BCD-digit decoder.
module dpd_unpack
  import dpd_pkg::*;
(
  input  logic [DECLET_W-1:0] in,
  output logic [DIGIT_W-1:0]  d2,
  output logic [DIGIT_W-1:0]  d1,
  output logic [DIGIT_W-1:0]  d0,
  output logic                noncanon
);

  logic w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_i, w_j;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_i, w_j} = in;
  assign noncanon = dpd_is_noncanon(in);

  // Large digits are 8/9 and carry only their LSB; {h,i} and {d,e} say which are large.
  always_comb begin
    d2 = {1'b0, w_a, w_b, w_c};
    d1 = {1'b0, w_d, w_e, w_f};
    d0 = {1'b0, w_h, w_i, w_j};
    if (w_g) begin
      case ({w_h, w_i})
        2'b00: begin
          d0 = {3'b100, w_j};
        end
        2'b01: begin
          d1 = {3'b100, w_f};
          d0 = {1'b0, w_d, w_e, w_j};
        end
        2'b10: begin
          d2 = {3'b100, w_c};
          d0 = {1'b0, w_a, w_b, w_j};
        end
        2'b11: begin
          case ({w_d, w_e})
            2'b00: begin
              d2 = {3'b100, w_c};
              d1 = {3'b100, w_f};
              d0 = {1'b0, w_a, w_b, w_j};
            end
            2'b01: begin
              d2 = {3'b100, w_c};
              d1 = {1'b0, w_a, w_b, w_f};
              d0 = {3'b100, w_j};
            end
            2'b10: begin
              d1 = {3'b100, w_f};
              d0 = {3'b100, w_j};
            end
            default: begin
              d2 = {3'b100, w_c};
              d1 = {3'b100, w_f};
              d0 = {3'b100, w_j};
            end
          endcase
        end
        default: begin
          d0 = {1'b0, w_h, w_i, w_j};
        end
      endcase
    end else begin
      d0 = {1'b0, w_h, w_i, w_j};
    end
  end

endmodule

// File: rtl/dpd_unpack_stream.sv
// Streaming DPD decoder: one declet in, three BCD digits out serially, with a non-canonical counter.
module dpd_unpack_stream
  import dpd_pkg::*;
#(
  parameter bit          MSD_FIRST = 1'b1,
  parameter int unsigned ERR_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DECLET_W-1:0] in_dpd,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIGIT_W-1:0]  out_digit,
  output logic                out_last,
  output logic                out_noncanon,
  output logic [ERR_W-1:0]    err_count
);

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  logic [DIGIT_W-1:0] w_dec_d2, w_dec_d1, w_dec_d0;
  logic               w_dec_noncanon;
  logic               w_in_hs, w_out_hs;
  logic [DIGIT_W-1:0] w_sel_digit;

  state_t             r_state;
  logic [1:0]         r_idx;
  bcd3_t              r_digits;
  logic               r_last;
  logic               r_noncanon;
  logic [ERR_W-1:0]   r_err_count;

  dpd_unpack u_unpack (
    .in       (in_dpd),
    .d2       (w_dec_d2),
    .d1       (w_dec_d1),
    .d0       (w_dec_d0),
    .noncanon (w_dec_noncanon)
  );

  assign out_valid = (r_state == ST_FULL);
  assign in_ready  = !out_valid | ((r_idx == 2'd2) & out_ready);
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;

  // An input handshake is only possible when empty or on the last digit, so it always means reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_idx      <= 2'd0;
      r_digits   <= '0;
      r_last     <= 1'b0;
      r_noncanon <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_hs) begin
            r_state    <= ST_FULL;
            r_idx      <= 2'd0;
            r_digits   <= '{d2: w_dec_d2, d1: w_dec_d1, d0: w_dec_d0};
            r_last     <= in_last;
            r_noncanon <= w_dec_noncanon;
          end
        end
        ST_FULL: begin
          if (w_in_hs) begin
            r_idx      <= 2'd0;
            r_digits   <= '{d2: w_dec_d2, d1: w_dec_d1, d0: w_dec_d0};
            r_last     <= in_last;
            r_noncanon <= w_dec_noncanon;
          end else if (w_out_hs) begin
            if (r_idx != 2'd2) begin
              r_idx <= r_idx + 2'd1;
            end else begin
              r_state <= ST_EMPTY;
              r_idx   <= 2'd0;
            end
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

  // Saturating tally of accepted non-canonical declets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_in_hs && w_dec_noncanon && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_ONE;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  // Index-to-digit mapping; idx 1 is always the tens digit.
  always_comb begin
    w_sel_digit = r_digits.d1;
    case (r_idx)
      2'd0: begin
        if (MSD_FIRST) w_sel_digit = r_digits.d2;
        else           w_sel_digit = r_digits.d0;
      end
      2'd1: begin
        w_sel_digit = r_digits.d1;
      end
      default: begin
        if (MSD_FIRST) w_sel_digit = r_digits.d0;
        else           w_sel_digit = r_digits.d2;
      end
    endcase
  end

  assign out_digit    = w_sel_digit;
  assign out_last     = r_last & (r_idx == 2'd2);
  assign out_noncanon = r_noncanon;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_dpd_unpack_stream.sv
// Directed self-checking bench for dpd_unpack_stream and the dpd_unpack decoder.
module tb_dpd_unpack_stream;
  import dpd_pkg::*;

  logic       clk = 1'b0;
  int         checks = 0;
  int         failures = 0;

  // Default instance
  logic       rst = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [9:0] in_dpd = 10'h000;
  logic       in_ready, out_valid, out_last, out_noncanon;
  logic [3:0] out_digit;
  logic [7:0] err_count;

  // LSD-first instance with a 2-bit error counter
  logic       b_rst = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b0;
  logic [9:0] b_in_dpd = 10'h000;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_noncanon;
  logic [3:0] b_out_digit;
  logic [1:0] b_err_count;

  // Standalone decoder for the loopback sweep
  logic [9:0] lb_dpd = 10'h000;
  logic [3:0] lb_d2, lb_d1, lb_d0;
  logic       lb_nc;

  always #5 clk = ~clk;

  dpd_unpack_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dpd(in_dpd),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_last(out_last), .out_noncanon(out_noncanon), .err_count(err_count)
  );

  dpd_unpack_stream #(.MSD_FIRST(1'b0), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_dpd(b_in_dpd),
    .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_digit(b_out_digit),
    .out_last(b_out_last), .out_noncanon(b_out_noncanon), .err_count(b_err_count)
  );

  dpd_unpack u_lb (.in(lb_dpd), .d2(lb_d2), .d1(lb_d1), .d0(lb_d0), .noncanon(lb_nc));

  // Independent BCD-to-DPD packer used as the reference encoder.
  function automatic logic [9:0] pack(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    case ({d2[3], d1[3], d0[3]})
      3'b000: pack = {d2[2:0], d1[2:0], 1'b0, d0[2:0]};
      3'b001: pack = {d2[2:0], d1[2:0], 1'b1, 2'b00, d0[0]};
      3'b010: pack = {d2[2:0], d0[2:1], d1[0], 1'b1, 2'b01, d0[0]};
      3'b100: pack = {d0[2:1], d2[0], d1[2:0], 1'b1, 2'b10, d0[0]};
      3'b110: pack = {d0[2:1], d2[0], 2'b00, d1[0], 3'b111, d0[0]};
      3'b101: pack = {d1[2:1], d2[0], 2'b01, d1[0], 3'b111, d0[0]};
      3'b011: pack = {d2[2:0], 2'b10, d1[0], 3'b111, d0[0]};
      default: pack = {2'b00, d2[0], 2'b11, d1[0], 3'b111, d0[0]};
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; b_rst = 1'b1; in_valid = 1'b0; b_in_valid = 1'b0;
    out_ready = 1'b0; b_out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; b_rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; b_rst = 1'b1; in_valid = 1'b1; in_dpd = 10'h0A3; in_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; b_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks += 7;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_digit !== 4'd0) begin failures++; $display("FAIL reset_out_digit got=%0d exp=0", out_digit); end
    if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    if (out_noncanon !== 1'b0) begin failures++; $display("FAIL reset_noncanon got=%b exp=0", out_noncanon); end
    if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (b_err_count !== 2'd0) begin failures++; $display("FAIL reset_b_err_count got=%0d exp=0", b_err_count); end
  endtask

  task automatic test_single();
    logic [3:0] exp_d [3];
    exp_d = '{4'd1, 4'd2, 4'd3};
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_dpd = 10'h0A3; in_last = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid k=%0d got=%b exp=1", k, out_valid); end
      if (out_digit !== exp_d[k]) begin failures++; $display("FAIL single_digit k=%0d got=%0d exp=%0d", k, out_digit, exp_d[k]); end
      if (out_last !== (k == 2)) begin failures++; $display("FAIL single_last k=%0d got=%b exp=%b", k, out_last, k == 2); end
      if (out_noncanon !== 1'b0) begin failures++; $display("FAIL single_noncanon k=%0d got=%b exp=0", k, out_noncanon); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [6];
    exp_d = '{4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0};
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_dpd = 10'h0FF; in_last = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 3) begin in_valid = 1'b1; in_dpd = 10'h000; in_last = 1'b1; end
      else begin in_valid = 1'b0; end
      #1;
      checks += 4;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, out_valid); end
      if (out_digit !== exp_d[k]) begin failures++; $display("FAIL b2b_digit k=%0d got=%0d exp=%0d", k, out_digit, exp_d[k]); end
      if (in_ready !== (k % 3 == 2)) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%b exp=%b", k, in_ready, k % 3 == 2); end
      if (out_last !== (k == 5)) begin failures++; $display("FAIL b2b_last k=%0d got=%b exp=%b", k, out_last, k == 5); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_noncanon();
    logic [9:0] decl [3];
    decl = '{10'h3FF, 10'h1FF, 10'h0FF};
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_dpd = decl[0]; in_last = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k / 3 + 1 < 3) begin in_valid = 1'b1; in_dpd = decl[k / 3 + 1]; end
      else begin in_valid = 1'b0; end
      #1;
      checks += 2;
      if (out_digit !== 4'd9) begin failures++; $display("FAIL nc_digit k=%0d got=%0d exp=9", k, out_digit); end
      if (out_noncanon !== (k < 6)) begin failures++; $display("FAIL nc_flag k=%0d got=%b exp=%b", k, out_noncanon, k < 6); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (err_count !== 8'd2) begin failures++; $display("FAIL nc_err_count got=%0d exp=2", err_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_dpd = 10'h0A3; in_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_digit !== 4'd1) begin failures++; $display("FAIL bp_first got=%0d exp=1", out_digit); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; in_dpd = 10'h000; in_last = 1'b0;
      #1;
      checks += 3;
      if (out_digit !== 4'd2) begin failures++; $display("FAIL bp_hold k=%0d got=%0d exp=2", k, out_digit); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, out_valid); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (out_digit !== 4'd2) begin failures++; $display("FAIL bp_resume2 got=%0d exp=2", out_digit); end
    @(negedge clk);
    #1;
    checks += 2;
    if (out_digit !== 4'd3) begin failures++; $display("FAIL bp_resume3 got=%0d exp=3", out_digit); end
    if (out_last !== 1'b1) begin failures++; $display("FAIL bp_last got=%b exp=1", out_last); end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_order_sat();
    logic [3:0] exp_d [3];
    exp_d = '{4'd3, 4'd2, 4'd1};
    do_reset();
    @(negedge clk);
    b_in_valid = 1'b1; b_in_dpd = 10'h0A3; b_in_last = 1'b1; b_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      checks += 2;
      if (b_out_digit !== exp_d[k]) begin failures++; $display("FAIL order_digit k=%0d got=%0d exp=%0d", k, b_out_digit, exp_d[k]); end
      if (b_out_last !== (k == 2)) begin failures++; $display("FAIL order_last k=%0d got=%b exp=%b", k, b_out_last, k == 2); end
    end
    @(negedge clk);
    b_in_valid = 1'b1; b_in_dpd = 10'h3FF; b_in_last = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      b_in_valid = (k / 3 + 1 < 5);
      #1;
      checks += 3;
      if (b_out_digit !== 4'd9) begin failures++; $display("FAIL sat_digit k=%0d got=%0d exp=9", k, b_out_digit); end
      if (b_out_noncanon !== 1'b1) begin failures++; $display("FAIL sat_flag k=%0d got=%b exp=1", k, b_out_noncanon); end
      if (b_in_ready !== (k % 3 == 2)) begin failures++; $display("FAIL sat_in_ready k=%0d got=%b exp=%b", k, b_in_ready, k % 3 == 2); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (b_err_count !== 2'd3) begin failures++; $display("FAIL sat_err_count got=%0d exp=3", b_err_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_dpd = 10'h0A3; in_last = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (out_digit !== 4'd2) begin failures++; $display("FAIL mid_pre got=%0d exp=2", out_digit); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_digit !== 4'd0) begin
        failures++; $display("FAIL mid_reset k=%0d valid=%b digit=%0d exp valid=0 digit=0", k, out_valid, out_digit);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] e2, e1, e0;
    int         nc_total;
    for (int n = 0; n < 1000; n++) begin
      e2 = 4'(n / 100); e1 = 4'((n / 10) % 10); e0 = 4'(n % 10);
      lb_dpd = pack(e2, e1, e0);
      #1;
      checks++;
      if ({lb_d2, lb_d1, lb_d0, lb_nc} !== {e2, e1, e0, 1'b0}) begin
        failures++;
        $display("FAIL loopback n=%0d dpd=%h got=%0d%0d%0d nc=%b", n, lb_dpd, lb_d2, lb_d1, lb_d0, lb_nc);
      end
    end
    nc_total = 0;
    for (int v = 0; v < 1024; v++) begin
      lb_dpd = 10'(v);
      #1;
      if (lb_nc) nc_total++;
    end
    checks++;
    if (nc_total != 24) begin failures++; $display("FAIL noncanon_total got=%0d exp=24", nc_total); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_noncanon();
    test_backpressure();
    test_order_sat();
    test_mid_reset();
    test_exhaustive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpd_unpack_stream.md
# dpd_unpack_stream

Streaming densely-packed-decimal decoder: accepts one 10-bit declet per handshake, expands it to three BCD digits, and emits them one digit per cycle on a valid/ready output. It is the receive-side counterpart of the BCD-to-DPD packer and sits between a declet source (FIFO or shift register) and digit-serial consumers such as display drivers or BCD arithmetic. It also flags the 24 non-canonical declets and keeps a saturating count of them.

## Interface
- `MSD_FIRST`, default 1: 1 emits digits hundreds→tens→ones; 0 emits ones→tens→hundreds.
- `ERR_W`, default 8: width of the non-canonical counter.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: `in_dpd`/`in_last` valid.
- `in_ready` output 1: block can accept a declet this cycle.
- `in_dpd` input 10: declet, bit order {a,b,c,d,e,f,g,h,i,j}, with `a` at bit 9.
- `in_last` input 1: declet is the final one of a number.
- `out_valid` output 1: `out_digit` is valid.
- `out_ready` input 1: consumer accepts the digit.
- `out_digit` output 4: BCD digit, 0–9 only.
- `out_last` output 1: final digit of a declet that carried `in_last`.
- `out_noncanon` output 1: the current digit's declet was non-canonical; held for all three digits.
- `err_count` output ERR_W: saturating count of accepted non-canonical declets.

## Operation
- **Decode.** Standard DPD decode.
  - Bit `g` (dpd[3]) = 0: all digits small. d2 = {0,a,b,c}, d1 = {0,d,e,f}, d0 = {0,h,i,j}.
  - Otherwise, select on {h,i} (dpd[2:1]) and, when {h,i}=11, on {d,e} (dpd[6:5]). Large digits are {100,x}, where x is the digit's LSB (c, f or j).
- **Non-canonical.** A declet is non-canonical when dpd[6], dpd[5], dpd[3], dpd[2] and dpd[1] are all 1 and (dpd[9] | dpd[8]) = 1.
  - Such a declet decodes as 8/9 in every position, with a and b ignored.
  - On acceptance, `err_count` increments, saturating at all-ones.
- **Storage and index.** A holding register stores the three decoded digits, the latched `in_last` and the noncanon flag. A 2-bit index `idx` runs 0→1→2.
  - `out_digit` = digit[idx], mapped through `MSD_FIRST`.
  - `out_last` = latched_last & (idx==2).
- **State.** Two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY, input handshake: latch the decoded declet, set idx=0, go to FULL.
  - FULL, output handshake with idx<2: idx increments.
  - FULL, output handshake with idx==2 and input handshake in the same cycle: reload, idx=0, stay FULL.
  - FULL, output handshake with idx==2 and no input handshake: go to EMPTY.
- **Ready.** `in_ready` = !out_valid | (idx==2 & out_ready). This is combinational from `out_ready`; there is no path from `in_valid` to `in_ready`.
- **Stability.** Outputs stay stable while `out_valid` & !`out_ready`. `in_dpd` is ignored unless `in_valid` & `in_ready`.

## Timing
- **Reset** (synchronous, wins over any handshake in the same cycle):
  - `out_valid`=0, `idx`=0, `out_digit`=0, `out_last`=0, `out_noncanon`=0, `err_count`=0.
  - `in_ready`=1 in the first cycle after reset.
- **Mid-declet reset.** Remaining digits are discarded and no partial output follows.
- **Latency.** 1 cycle from input handshake to first `out_valid`.
- **Throughput.** Sustained 3 cycles per declet with `out_ready` held high; no bubble between declets.
- **Backpressure.** `out_ready`=0 freezes `idx`, the outputs and `in_ready`=0.
- **Saturation.** `err_count` at saturation remains at all-ones.

## Structure
- Package `dpd_pkg` holds:
  - `DECLET_W`=10 and `DIGIT_W`=4.
  - A `bcd3_t` struct {d2,d1,d0}.
  - A `dpd_is_noncanon` function.
- Combinational sub-module `dpd_unpack`: `in` dpd[9:0], outputs d2/d1/d0[3:0] and `noncanon`. It is the exact inverse of the packer on all 1000 canonical codes.
- `dpd_unpack_stream` contains only the holding register, index, FSM and counter.

## Test plan
- **Single declet, MSD_FIRST=1.** `in_dpd`=0x0A3 with `in_last`=1 and `out_ready`=1 → digits 1,2,3 on consecutive cycles starting 1 cycle after the handshake; `out_last` high only on the 3; `out_noncanon`=0.
- **Back-to-back.** 0x0FF then 0x000, `out_ready` high → digits 9,9,9,0,0,0 with no gap; `in_ready` pulses on each idx==2 cycle.
- **Non-canonical.** 0x3FF, then 0x1FF, then 0x0FF → each decodes to 9,9,9; `out_noncanon` = 1,1,0 per declet; `err_count` ends at 2.
- **Backpressure.** 0x0A3 with `out_ready` low for 4 cycles on idx=1 → the digit 2 holds steady and `in_ready`=0 throughout; sequence resumes as 3.
- **Order and saturation.** `MSD_FIRST`=0 with 0x0A3 → 3,2,1. `ERR_W`=2 with 5 non-canonical declets → `err_count` = 3.
- **Reset and exhaustive.** `rst` asserted at idx=1 → `out_valid`=0 next cycle and no remaining digits. Then an exhaustive packer→`dpd_unpack` loopback over 000–999 shows zero mismatches.
